// File: rtl/mem_arbiter.sv
// mem_arbiter: lets the instruction-fetch (IF) and load/store (DM) ports share one
// single-port SRAM. DM has fixed priority and IF is forced through after MAX_STREAK
// consecutive DM grants. Read data comes back one cycle after the grant, tagged by
// a registered owner.
// Optional feature: define ARB_PERF_CNT_EN to add the perf_if_wait_o / perf_dm_cnt_o
// counters.
module mem_arbiter #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 32,
    parameter int MAX_STREAK = 3
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                if_req_i,
    input  logic [ADDR_W-1:0]   if_addr_i,
    output logic                if_gnt_o,
    output logic                if_rvalid_o,
    output logic [DATA_W-1:0]   if_rdata_o,
    input  logic                dm_req_i,
    input  logic [DATA_W/8-1:0] dm_w_en_i,
    input  logic [ADDR_W-1:0]   dm_addr_i,
    input  logic [DATA_W-1:0]   dm_wdata_i,
    output logic                dm_gnt_o,
    output logic                dm_rvalid_o,
    output logic [DATA_W-1:0]   dm_rdata_o,
    output logic [DATA_W/8-1:0] sram_w_en_o,
    output logic [ADDR_W-1:0]   sram_address_o,
    output logic [DATA_W-1:0]   sram_write_data_o,
    input  logic [DATA_W-1:0]   sram_read_data_i
`ifdef ARB_PERF_CNT_EN
    ,
    output logic [31:0]         perf_if_wait_o,
    output logic [31:0]         perf_dm_cnt_o
`endif
);

    localparam logic [3:0] MaxStreak = 4'(MAX_STREAK);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_DM   = 2'd2
    } own_e;

    own_e       rdOwn_q, rdOwn_d;
    logic [3:0] streak_q, streak_d;
    logic       ifGnt, dmGnt, forceIf;

    // Pick at most one requester this cycle: a starved IF wins, otherwise DM, otherwise IF.
    always_comb begin
        ifGnt   = 1'b0;
        dmGnt   = 1'b0;
        forceIf = if_req_i && (streak_q == MaxStreak);
        if (forceIf) begin
            ifGnt = 1'b1;
        end else if (dm_req_i) begin
            dmGnt = 1'b1;
        end else if (if_req_i) begin
            ifGnt = 1'b1;
        end
    end

    // Steer the granted requester onto the SRAM; idle cycles drive all zeros.
    always_comb begin
        sram_w_en_o       = '0;
        sram_address_o    = '0;
        sram_write_data_o = '0;
        if (dmGnt) begin
            sram_w_en_o       = dm_w_en_i;
            sram_address_o    = dm_addr_i;
            sram_write_data_o = dm_wdata_i;
        end else if (ifGnt) begin
            sram_address_o = if_addr_i;
        end
    end

    // Next streak length and next read-data owner.
    always_comb begin
        streak_d = streak_q;
        rdOwn_d  = OWN_NONE;
        if (ifGnt || !if_req_i) begin
            streak_d = '0;
        end else if (dmGnt && (streak_q < MaxStreak)) begin
            streak_d = streak_q + 4'd1;
        end
        if (ifGnt) begin
            rdOwn_d = OWN_IF;
        end else if (dmGnt && (dm_w_en_i == '0)) begin
            rdOwn_d = OWN_DM;
        end
    end

    // Arbitration state; reset drops any read still in flight.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rdOwn_q  <= OWN_NONE;
            streak_q <= '0;
        end else begin
            rdOwn_q  <= rdOwn_d;
            streak_q <= streak_d;
        end
    end

    assign if_gnt_o    = ifGnt;
    assign dm_gnt_o    = dmGnt;
    assign if_rvalid_o = (rdOwn_q == OWN_IF);
    assign dm_rvalid_o = (rdOwn_q == OWN_DM);
    assign if_rdata_o  = sram_read_data_i;
    assign dm_rdata_o  = sram_read_data_i;

`ifdef ARB_PERF_CNT_EN
    logic [31:0] perfIfWait_q, perfDmCnt_q;

    // Free-running wrap-around counters of IF stall cycles and DM grants.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            perfIfWait_q <= '0;
            perfDmCnt_q  <= '0;
        end else begin
            if (if_req_i && !ifGnt) begin
                perfIfWait_q <= perfIfWait_q + 32'd1;
            end
            if (dmGnt) begin
                perfDmCnt_q <= perfDmCnt_q + 32'd1;
            end
        end
    end

    assign perf_if_wait_o = perfIfWait_q;
    assign perf_dm_cnt_o  = perfDmCnt_q;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios followed by randomized IF/DM traffic, checked
// against a transaction-level reference model with its own copy of the SRAM contents.
// Define ARB_PERF_CNT_EN to also check the performance counters.
module tb_mem_arbiter;

   logic        clk;
   logic        rstN;
   logic        ifReq;
   logic [15:0] ifAddr;
   logic        ifGnt, ifRvalid;
   logic [31:0] ifRdata;
   logic        dmReq;
   logic [3:0]  dmWEn;
   logic [15:0] dmAddr;
   logic [31:0] dmWdata;
   logic        dmGnt, dmRvalid;
   logic [31:0] dmRdata;
   logic [3:0]  sramWEn;
   logic [15:0] sramAddr;
   logic [31:0] sramWdata;
   logic [31:0] sramRdata;
`ifdef ARB_PERF_CNT_EN
   logic [31:0] perfIfWait, perfDmCnt;
`endif

   int checkCount = 0;
   int failCount  = 0;

   logic [31:0] sramMem [64];
   logic [31:0] refMem  [64];

   int          refStreak;
   int          prevOwn;
   logic [31:0] expData;
   int          modelWait;
   int          modelDmCnt;
   bit          ifDone, dmDone;

   localparam int MaxStreak = 3;

   mem_arbiter #(.ADDR_W(16), .DATA_W(32), .MAX_STREAK(MaxStreak)) dut (
      .clk_i(clk), .rst_ni(rstN),
      .if_req_i(ifReq), .if_addr_i(ifAddr), .if_gnt_o(ifGnt),
      .if_rvalid_o(ifRvalid), .if_rdata_o(ifRdata),
      .dm_req_i(dmReq), .dm_w_en_i(dmWEn), .dm_addr_i(dmAddr), .dm_wdata_i(dmWdata),
      .dm_gnt_o(dmGnt), .dm_rvalid_o(dmRvalid), .dm_rdata_o(dmRdata),
      .sram_w_en_o(sramWEn), .sram_address_o(sramAddr),
      .sram_write_data_o(sramWdata), .sram_read_data_i(sramRdata)
`ifdef ARB_PERF_CNT_EN
      , .perf_if_wait_o(perfIfWait), .perf_dm_cnt_o(perfDmCnt)
`endif
   );

   // Free-running clock, rising edges at 5, 15, 25 ...
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural single-port SRAM: read-first, byte-writable, data one cycle after address.
   always @(posedge clk) begin
      sramRdata <= sramMem[sramAddr[5:0]];
      for (int b = 0; b < 4; b++) begin
         if (sramWEn[b]) sramMem[sramAddr[5:0]][b*8 +: 8] <= sramWdata[b*8 +: 8];
      end
   end

   // Count one comparison and report it if observed and expected differ.
   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checkCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
      end
   endtask

   // Reference model: decide the grant from the arbitration rules, compare every output,
   // then advance streak, outstanding read and memory contents.
   task automatic modelCycle();
      bit          expIf, expDm;
      logic [3:0]  expWEn;
      logic [15:0] expAddr;
      logic [31:0] expWdata;
      expIf = 1'b0;
      expDm = 1'b0;
      if (ifReq && refStreak == MaxStreak) expIf = 1'b1;
      else if (dmReq)                      expDm = 1'b1;
      else if (ifReq)                      expIf = 1'b1;
      expWEn   = expDm ? dmWEn : 4'd0;
      expAddr  = expIf ? ifAddr : (expDm ? dmAddr : 16'd0);
      expWdata = expDm ? dmWdata : 32'd0;
      checkOutput("if_gnt", ifGnt, expIf);
      checkOutput("dm_gnt", dmGnt, expDm);
      checkOutput("sram_w_en", sramWEn, expWEn);
      checkOutput("sram_address", sramAddr, expAddr);
      if (!expIf) checkOutput("sram_write_data", sramWdata, expWdata);
      checkOutput("if_rvalid", ifRvalid, prevOwn == 1);
      checkOutput("dm_rvalid", dmRvalid, prevOwn == 2);
      if (prevOwn == 1) checkOutput("if_rdata", ifRdata, expData);
      if (prevOwn == 2) checkOutput("dm_rdata", dmRdata, expData);
`ifdef ARB_PERF_CNT_EN
      checkOutput("perf_if_wait", perfIfWait, modelWait);
      checkOutput("perf_dm_cnt", perfDmCnt, modelDmCnt);
`endif
      if (ifReq && !expIf) modelWait++;
      if (expDm) modelDmCnt++;
      if (expIf || !ifReq) refStreak = 0;
      else if (expDm && refStreak < MaxStreak) refStreak++;
      prevOwn = 0;
      if (expIf) begin
         prevOwn = 1;
         expData = refMem[ifAddr[5:0]];
      end else if (expDm) begin
         if (dmWEn == 4'd0) begin
            prevOwn = 2;
            expData = refMem[dmAddr[5:0]];
         end
         for (int b = 0; b < 4; b++) begin
            if (dmWEn[b]) refMem[dmAddr[5:0]][b*8 +: 8] = dmWdata[b*8 +: 8];
         end
      end
      ifDone = expIf;
      dmDone = expDm;
   endtask

   // Check at the falling edge, then land just after the next rising edge.
   task automatic stepCycle();
      @(negedge clk);
      modelCycle();
      @(posedge clk);
      #1;
   endtask

   // Clear the model state that the DUT reset clears.
   task automatic resetModel();
      refStreak  = 0;
      prevOwn    = 0;
      modelWait  = 0;
      modelDmCnt = 0;
   endtask

   // Pulse reset with no requests; release on a falling edge.
   task automatic doReset();
      ifReq = 1'b0;
      dmReq = 1'b0;
      rstN  = 1'b0;
      #3;
      resetModel();
      @(negedge clk);
      rstN = 1'b1;
      @(posedge clk);
      #1;
   endtask

   // Hold both requesters for n cycles and check the 3-DM-then-IF grant rhythm.
   task automatic runBothHeld(input int n);
      for (int k = 0; k < n; k++) begin
         ifReq  = 1'b1;
         ifAddr = 16'(k);
         dmReq  = 1'b1;
         dmWEn  = 4'd0;
         dmAddr = 16'(32 + k);
         #1;
         checkOutput("order_if", ifGnt, (k % 4) == 3);
         checkOutput("order_dm", dmGnt, (k % 4) != 3);
         stepCycle();
      end
      ifReq = 1'b0;
      dmReq = 1'b0;
   endtask

   // Random request traffic: requests are held until granted, may be withdrawn early,
   // and a new request may follow a grant immediately.
   task automatic applyStimulus();
      if (ifReq && (ifDone || $urandom_range(15) == 0)) ifReq = 1'b0;
      if (!ifReq && $urandom_range(3) != 0) begin
         ifReq  = 1'b1;
         ifAddr = 16'($urandom_range(63));
      end
      if (dmReq && (dmDone || $urandom_range(15) == 0)) dmReq = 1'b0;
      if (!dmReq && $urandom_range(4) != 0) begin
         dmReq   = 1'b1;
         dmAddr  = 16'($urandom_range(63));
         dmWdata = $urandom;
         dmWEn   = ($urandom_range(1) == 0) ? 4'd0 : 4'($urandom_range(15));
      end
      ifDone = 1'b0;
      dmDone = 1'b0;
   endtask

   // Test sequence: directed scenarios, then randomized traffic, then the summary.
   initial begin
      logic [31:0] v;
      rstN    = 1'b0;
      ifReq   = 1'b0;
      ifAddr  = '0;
      dmReq   = 1'b0;
      dmWEn   = '0;
      dmAddr  = '0;
      dmWdata = '0;
      ifDone  = 1'b0;
      dmDone  = 1'b0;
      expData = '0;
      for (int i = 0; i < 64; i++) begin
         v = $urandom;
         sramMem[i] = v;
         refMem[i]  = v;
      end
      sramMem[4] = 32'h00500093;
      refMem[4]  = 32'h00500093;

      // Reset state with no requests.
      doReset();
      #1;
      checkOutput("rst_if_gnt", ifGnt, 1'b0);
      checkOutput("rst_dm_gnt", dmGnt, 1'b0);
      checkOutput("rst_if_rvalid", ifRvalid, 1'b0);
      checkOutput("rst_dm_rvalid", dmRvalid, 1'b0);
      checkOutput("rst_sram_w_en", sramWEn, 4'd0);
      stepCycle();

      // Single IF fetch.
      ifReq  = 1'b1;
      ifAddr = 16'h0004;
      #1;
      checkOutput("fetch_gnt", ifGnt, 1'b1);
      stepCycle();
      ifReq = 1'b0;
      #1;
      checkOutput("fetch_rvalid", ifRvalid, 1'b1);
      checkOutput("fetch_rdata", ifRdata, 32'h00500093);
      stepCycle();

      // Contention from a fresh reset: DM,DM,DM,IF repeating.
      doReset();
      runBothHeld(8);
`ifdef ARB_PERF_CNT_EN
      #1;
      checkOutput("perf_dm_after8", perfDmCnt, 32'd6);
      checkOutput("perf_wait_after8", perfIfWait, 32'd6);
`endif
      stepCycle();

      // DM partial store: no read data returned.
      dmReq   = 1'b1;
      dmWEn   = 4'b0011;
      dmAddr  = 16'h0010;
      dmWdata = 32'hDEADBEEF;
      #1;
      checkOutput("store_w_en", sramWEn, 4'b0011);
      checkOutput("store_addr", sramAddr, 16'h0010);
      stepCycle();
      dmWEn = 4'b0000;
      #1;
      checkOutput("store_no_rvalid", dmRvalid, 1'b0);
      stepCycle();
      dmReq = 1'b0;
      stepCycle();

      // Reset while an IF read is outstanding.
      ifReq  = 1'b1;
      ifAddr = 16'h0008;
      stepCycle();
      ifReq = 1'b0;
      #1;
      checkOutput("pre_rst_rvalid", ifRvalid, 1'b1);
      rstN = 1'b0;
      #1;
      checkOutput("rst_drops_rvalid", ifRvalid, 1'b0);
      resetModel();
      @(negedge clk);
      rstN = 1'b1;
      @(posedge clk);
      #1;
      runBothHeld(4);
      stepCycle();

      // Randomized traffic.
      for (int c = 0; c < 3000; c++) begin
         applyStimulus();
         stepCycle();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
      $finish;
   end

endmodule
